c499_key_loader: RTL and testbench

Sequential key-delivery stage directly upstream of the MUX2-locked c499 SEC core. Receives the obfuscation key as a framed serial bitstream from the key store and checks the frame's sync pattern, parity and inter-bit timeout. Drives the core's key inputs `s_0`/`s_1` only after a frame passes all checks, and counts failed frames up to a sticky lockout.

---
 rtl/c499_key_pkg.sv | 29 ++
 rtl/c499_key_shift.sv | 78 +++++++
 rtl/c499_key_loader.sv | 197 +++++++++++++++++++
 tb/tb_c499_key_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c499_key_pkg.sv
// -----------------------------------------------------------------------------
// c499_key_pkg
// Shared definitions for the c499 key loader:
//   - key_state_e   : loader FSM state encoding (also exported on dbg_state)
//   - SYNC_W        : frame header width
//   - SYNC_PAT_DEF  : default frame header pattern (received MSB first)
//   - err_cnt_width : width of the failed-frame counter for a given retry limit
// -----------------------------------------------------------------------------
package c499_key_pkg;

   localparam int SYNC_W = 4;
   localparam logic [SYNC_W-1:0] SYNC_PAT_DEF = 4'hA;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HUNT  = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PAR   = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5,
      ST_LOCK  = 3'd6
   } key_state_e;

   // Counter must be able to hold the value max_retry itself.
   function automatic int err_cnt_width(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction

endpackage

// File: rtl/c499_key_shift.sv
// -----------------------------------------------------------------------------
// c499_key_shift
// Serial shift register, sync-window compare and key staging for the key loader.
// Optional feature macro: C499_KEY_PARITY_EN (frame carries a trailing parity bit).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   shift_en   : sample sdi into the shift register this cycle
//   clr        : clear shift register and staging (priority over shift/snap)
//   snap       : copy the key field (and parity) of the post-shift window into staging
//   sdi        : serial data bit
//   sync_hit   : window including the current sdi equals SYNC_PAT
//   key_stage  : staged key bits (never drive the core directly)
//   par_ok     : staged key plus parity has even parity (always 1 without parity)
// -----------------------------------------------------------------------------
module c499_key_shift
   import c499_key_pkg::*;
#(
   parameter int KEY_W = 2,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             clr,
   input  logic             snap,
   input  logic             sdi,
   output logic             sync_hit,
   output logic [KEY_W-1:0] key_stage,
   output logic             par_ok
);

   // Window must cover both the sync header and the key+parity field.
   localparam int WIN_W = (SYNC_W > KEY_W + 1) ? SYNC_W : KEY_W + 1;

   logic [WIN_W-2:0] sr;
   logic [WIN_W-1:0] sr_next;

   // The bit being sampled now is part of the window, so a header match is
   // seen on the same edge that delivers its last bit.
   assign sr_next  = {sr, sdi};
   assign sync_hit = (sr_next[SYNC_W-1:0] == SYNC_PAT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         sr <= '0;
      end else if (shift_en) begin
         sr <= sr_next[WIN_W-2:0];
      end
   end

`ifdef C499_KEY_PARITY_EN
   logic par_bit;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         key_stage <= '0;
         par_bit   <= 1'b0;
      end else if (snap) begin
         key_stage <= sr_next[KEY_W:1];
         par_bit   <= sr_next[0];
      end
   end

   assign par_ok = ~(^{key_stage, par_bit});
`else
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         key_stage <= '0;
      end else if (snap) begin
         key_stage <= sr_next[KEY_W-1:0];
      end
   end

   assign par_ok = 1'b1;
`endif

endmodule

// File: rtl/c499_key_loader.sv
// -----------------------------------------------------------------------------
// c499_key_loader
// Receives the c499 obfuscation key as a framed serial bitstream
// (sync header, KEY_W key bits MSB first, optional parity bit), validates it
// and only then drives the core key inputs s_0/s_1. Failed frames are counted;
// MAX_RETRY failures lock the loader until reset.
// Optional feature macro: C499_KEY_PARITY_EN (parity bit present and checked).
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_req    : one-cycle request to (re)load the key (IDLE/DONE only)
//   key_sdi     : serial key data
//   key_sdv     : key_sdi valid; there is no backpressure, every cycle with
//                 key_sdv=1 delivers exactly one bit, key_sdv=0 stalls the FSM
//   s_0, s_1    : verified key bits to the core
//   key_valid   : key verified and applied
//   key_err     : one-cycle pulse per failed frame
//   key_lockout : sticky lockout after MAX_RETRY failures
//   err_cnt     : number of failed frames
//   dbg_state   : current FSM state (key_state_e encoding)
// -----------------------------------------------------------------------------
module c499_key_loader
   import c499_key_pkg::*;
#(
   parameter int KEY_W = 2,
   parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load_req,
   input  logic key_sdi,
   input  logic key_sdv,
   output logic s_0,
   output logic s_1,
   output logic key_valid,
   output logic key_err,
   output logic key_lockout,
   output logic [err_cnt_width(MAX_RETRY)-1:0] err_cnt,
   output logic [2:0] dbg_state
);

   localparam int CNT_W  = err_cnt_width(MAX_RETRY);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int BC_W   = $clog2(KEY_W + 1);

   key_state_e        state;
   logic [IDLE_W-1:0] idle_cnt;
   logic [BC_W-1:0]   bit_cnt;

   logic             shift_en;
   logic             clr;
   logic             snap;
   logic             sync_hit;
   logic [KEY_W-1:0] key_stage;
   logic             par_ok;

   logic             last_key;
   logic             timeout_now;
   logic             check_fail;
   logic             err_now;
   logic [CNT_W-1:0] err_inc;

   assign dbg_state = state;

   assign shift_en = key_sdv &&
                     ((state == ST_HUNT) || (state == ST_LOAD) || (state == ST_PAR));
   assign last_key = (state == ST_LOAD) && key_sdv && (bit_cnt == BC_W'(KEY_W - 1));

`ifdef C499_KEY_PARITY_EN
   assign snap = (state == ST_PAR) && key_sdv;
`else
   assign snap = last_key;
`endif

   // Timeout fires on the edge where the idle run reaches TIMEOUT.
   assign timeout_now = ((state == ST_LOAD) || (state == ST_PAR)) && !key_sdv &&
                        (idle_cnt == IDLE_W'(TIMEOUT - 1));
   assign check_fail  = (state == ST_CHECK) && !par_ok;
   assign err_now     = timeout_now || check_fail;
   assign err_inc     = err_cnt + 1'b1;

   // Every entry into HUNT starts from an empty window and empty staging.
   assign clr = ((state == ST_IDLE) && load_req) ||
                ((state == ST_DONE) && load_req) ||
                err_now;

   c499_key_shift #(
      .KEY_W    (KEY_W),
      .SYNC_PAT (SYNC_PAT)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (shift_en),
      .clr       (clr),
      .snap      (snap),
      .sdi       (key_sdi),
      .sync_hit  (sync_hit),
      .key_stage (key_stage),
      .par_ok    (par_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idle_cnt    <= '0;
         bit_cnt     <= '0;
         s_0         <= 1'b0;
         s_1         <= 1'b0;
         key_valid   <= 1'b0;
         key_err     <= 1'b0;
         key_lockout <= 1'b0;
         err_cnt     <= '0;
      end else begin
         key_err <= 1'b0;
         if (err_now) begin
            key_err  <= 1'b1;
            err_cnt  <= err_inc;
            idle_cnt <= '0;
            bit_cnt  <= '0;
            if (err_inc == CNT_W'(MAX_RETRY)) begin
               state       <= ST_LOCK;
               key_lockout <= 1'b1;
               s_0         <= 1'b0;
               s_1         <= 1'b0;
               key_valid   <= 1'b0;
            end else begin
               state <= ST_HUNT;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  if (load_req) state <= ST_HUNT;
               end
               ST_HUNT: begin
                  if (key_sdv && sync_hit) begin
                     state    <= ST_LOAD;
                     bit_cnt  <= '0;
                     idle_cnt <= '0;
                  end
               end
               ST_LOAD: begin
                  if (key_sdv) begin
                     idle_cnt <= '0;
                     if (last_key) begin
                        bit_cnt <= '0;
`ifdef C499_KEY_PARITY_EN
                        state   <= ST_PAR;
`else
                        state   <= ST_CHECK;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
`ifdef C499_KEY_PARITY_EN
               ST_PAR: begin
                  if (key_sdv) begin
                     idle_cnt <= '0;
                     state    <= ST_CHECK;
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
`endif
               ST_CHECK: begin
                  // Failing checks are handled by err_now above.
                  s_0       <= key_stage[0];
                  s_1       <= key_stage[1];
                  key_valid <= 1'b1;
                  state     <= ST_DONE;
               end
               ST_DONE: begin
                  if (load_req) begin
                     s_0       <= 1'b0;
                     s_1       <= 1'b0;
                     key_valid <= 1'b0;
                     state     <= ST_HUNT;
                  end
               end
               ST_LOCK: begin
                  key_lockout <= 1'b1;
                  s_0         <= 1'b0;
                  s_1         <= 1'b0;
                  key_valid   <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_c499_key_loader.sv
// -----------------------------------------------------------------------------
// tb_c499_key_loader
// Directed bench for c499_key_loader at default parameters. Works with and
// without C499_KEY_PARITY_EN; without parity a "failing frame" is produced by
// an inter-bit timeout instead of a bad parity bit.
// Event record layout: {s_1, s_0, key_valid, key_err, key_lockout, err_cnt[1:0]}
// -----------------------------------------------------------------------------
module tb_c499_key_loader;
   import c499_key_pkg::*;

`ifdef C499_KEY_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       load_req;
   logic       key_sdi;
   logic       key_sdv;
   logic       s_0;
   logic       s_1;
   logic       key_valid;
   logic       key_err;
   logic       key_lockout;
   logic [1:0] err_cnt;
   logic [2:0] dbg_state;

   int checks = 0;
   int errors = 0;

   logic [6:0] exp_q[$];
   logic [6:0] mon_act;
   logic [6:0] mon_exp;
   logic       prev_valid;
   logic       prev_lock;

   c499_key_loader dut (
      .clk         (clk),
      .rst         (rst),
      .load_req    (load_req),
      .key_sdi     (key_sdi),
      .key_sdv     (key_sdv),
      .s_0         (s_0),
      .s_1         (s_1),
      .key_valid   (key_valid),
      .key_err     (key_err),
      .key_lockout (key_lockout),
      .err_cnt     (err_cnt),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers / driver tasks ----------------
   function automatic logic [6:0] rec(input logic s1, input logic s0, input logic v,
                                      input logic e, input logic l, input logic [1:0] c);
      return {s1, s0, v, e, l, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      key_sdi = b;
      key_sdv = 1'b1;
      tick();
      key_sdv = 1'b0;
   endtask

   // Good frame: sync 1010, key 01 (s_0=1, s_1=0), parity 1 when present.
   task automatic send_good(input int gap);
      logic [6:0] bits;
      int         n;
      bits = 7'b1010011;
      n    = PAR_EN ? 7 : 6;
      for (int i = 0; i < n; i++) begin
         if (i != 0) idle(gap);
         send_bit(bits[6-i]);
      end
   endtask

   task automatic send_bad();
      if (PAR_EN) begin
         send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
         send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      end else begin
         send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
         send_bit(1'b0);
         idle(16);
      end
   endtask

   // ---------------- checkers ----------------
   task automatic check_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_v(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check_b({name, "_s_0"}, s_0, 1'b0);
      check_b({name, "_s_1"}, s_1, 1'b0);
      check_b({name, "_key_valid"}, key_valid, 1'b0);
      check_b({name, "_key_err"}, key_err, 1'b0);
      check_b({name, "_key_lockout"}, key_lockout, 1'b0);
      check_v({name, "_err_cnt"}, 8'(err_cnt), 8'd0);
      check_v({name, "_state"}, 8'(dbg_state), 8'(ST_IDLE));
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected events still pending after %0d cycles",
                  name, exp_q.size(), max_cycles);
         exp_q.delete();
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (key_err || (key_valid && !prev_valid) || (key_lockout && !prev_lock)) begin
            mon_act = {s_1, s_0, key_valid, key_err, key_lockout, err_cnt};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got %b, expected none", mon_act);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_act !== mon_exp) begin
                  errors++;
                  $display("FAIL event: got %b, expected %b", mon_act, mon_exp);
               end
            end
         end
      end
      prev_valid <= rst ? 1'b0 : key_valid;
      prev_lock  <= rst ? 1'b0 : key_lockout;
   end

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b1;
      load_req = 1'b0;
      key_sdi  = 1'b0;
      key_sdv  = 1'b0;
      do_reset();
      check_zero("reset");

      // Good frame with exact latency.
      pulse_load();
      check_v("state_after_load", 8'(dbg_state), 8'(ST_HUNT));
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
      send_good(0);
      check_b("valid_not_before_check", key_valid, 1'b0);
      check_v("state_check", 8'(dbg_state), 8'(ST_CHECK));
      tick();
      check_b("good_valid", key_valid, 1'b1);
      check_b("good_s_0", s_0, 1'b1);
      check_b("good_s_1", s_1, 1'b0);
      check_v("good_err_cnt", 8'(err_cnt), 8'd0);
      wait_drain("good_drain", 10);

      // Reload from DONE clears, then a failing frame, then recovery.
      pulse_load();
      check_b("reload_clears_valid", key_valid, 1'b0);
      check_b("reload_clears_s_0", s_0, 1'b0);
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
      send_bad();
      wait_drain("bad_drain", 10);
      tick();
      check_b("bad_err_one_cycle", key_err, 1'b0);
      check_b("bad_valid", key_valid, 1'b0);
      check_b("bad_s_0", s_0, 1'b0);
      check_v("bad_err_cnt", 8'(err_cnt), 8'd1);
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1));
      send_good(0);
      wait_drain("recover_drain", 10);

      // Timeout after sync + one key bit.
      pulse_load();
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b0);
      idle(15);
      check_b("no_err_at_15_idle", key_err, 1'b0);
      check_v("pending_at_15_idle", 8'(exp_q.size()), 8'd1);
      idle(1);
      check_b("err_at_16_idle", key_err, 1'b1);
      check_v("state_after_timeout", 8'(dbg_state), 8'(ST_HUNT));
      wait_drain("timeout_drain", 5);

      // 15 idle cycles are tolerated.
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2));
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b0);
      idle(15);
      send_bit(1'b1);
      if (PAR_EN) send_bit(1'b1);
      wait_drain("idle15_drain", 10);

      // Reset mid-frame.
      pulse_load();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b0);
      do_reset();
      check_zero("mid_frame_reset");
      pulse_load();
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
      send_good(0);
      wait_drain("after_reset_drain", 10);

      // Stalled good frame.
      pulse_load();
      check_b("stall_reload_valid", key_valid, 1'b0);
      exp_q.push_back(rec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
      send_good(1);
      wait_drain("stall_drain", 10);

      // Lockout after three failures.
      pulse_load();
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
      send_bad();
      wait_drain("lock1_drain", 10);
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
      send_bad();
      wait_drain("lock2_drain", 10);
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3));
      send_bad();
      wait_drain("lock3_drain", 10);
      check_v("state_lock", 8'(dbg_state), 8'(ST_LOCK));
      send_good(0);
      idle(3);
      pulse_load();
      send_good(0);
      idle(3);
      check_b("lock_valid", key_valid, 1'b0);
      check_b("lock_s_0", s_0, 1'b0);
      check_b("lock_sticky", key_lockout, 1'b1);
      check_v("lock_err_cnt", 8'(err_cnt), 8'd3);
      do_reset();
      check_zero("lock_reset");

      check_v("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
